// File: rtl/scanchain_pkg.sv
// Shared scan-chain definitions: frame field widths used by the UART client,
// writer FSM states and default timing.
package scanchain_pkg;

  localparam int SCAN_ADDR_BITS     = 12;
  localparam int SCAN_PAYLOAD_BITS  = 160;
  localparam int SCAN_HALF_PERIOD   = 4;
  localparam int SCAN_RESET_PERIODS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE,
    ST_RESET_PULSE
  } scan_state_e;

endpackage

// File: rtl/scanchain_phase_timer.sv
// Half-period down-counter for the scan clock: half_tick_o marks the last cycle
// of each half period, phase_o is the scan_clk level for the current half.
module scanchain_phase_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic half_tick_o,
  output logic phase_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  assign half_tick_o = (cnt_q == '0);
  assign phase_o     = phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= RELOAD;
      phase_q <= 1'b0;
    end else if (half_tick_o) begin
      cnt_q   <= RELOAD;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/scanchain_writer.sv
// Turns accepted {addr, payload} writes into a bit-serial scan shift plus update
// strobe, or into a scan-reset pulse when the write carries the reset flag.
//
// state          | meaning
// ST_IDLE        | ready for a write, scan pins quiet
// ST_SHIFT       | shifting frame LSB first, one bit per scan_clk period
// ST_UPDATE      | one scan_clk period of scan_update after the last bit
// ST_RESET_PULSE | scan_reset held for RESET_PERIODS scan_clk periods
module scanchain_writer
  import scanchain_pkg::*;
#(
  parameter int ADDR_BITS     = SCAN_ADDR_BITS,
  parameter int PAYLOAD_BITS  = SCAN_PAYLOAD_BITS,
  parameter int HALF_PERIOD   = SCAN_HALF_PERIOD,
  parameter int RESET_PERIODS = SCAN_RESET_PERIODS
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    write_ready,
  input  logic                    write_valid,
  input  logic [ADDR_BITS-1:0]    write_addr,
  input  logic [PAYLOAD_BITS-1:0] write_payload,
  input  logic                    write_reset,
  output logic                    scan_clk,
  output logic                    scan_en,
  output logic                    scan_in,
  output logic                    scan_update,
  output logic                    scan_reset
);

  localparam int FRAME_BITS = ADDR_BITS + PAYLOAD_BITS;
  localparam int FB_W       = $clog2(FRAME_BITS + 1);
  localparam int RP_W       = $clog2(RESET_PERIODS + 1);
  localparam int CNT_W      = (FB_W > RP_W) ? FB_W : RP_W;

  scan_state_e           state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, sclk_q, sen_q, sin_q, supd_q, srst_q;
  logic                  accept, half_tick, phase, period_end, timer_clr;

  assign accept     = write_valid && ready_q;
  assign period_end = half_tick && phase;
  assign timer_clr  = (state_d != state_q);

  scanchain_phase_timer #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phase_timer (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (timer_clr),
    .half_tick_o (half_tick),
    .phase_o     (phase)
  );

  // cnt_q counts remaining bits (SHIFT) or remaining periods (RESET_PULSE)
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d = {write_payload, write_addr};
          if (write_reset) begin
            state_d = ST_RESET_PULSE;
            cnt_d   = CNT_W'(RESET_PERIODS - 1);
          end else begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_W'(FRAME_BITS - 1);
          end
        end
      end
      ST_SHIFT: begin
        if (period_end) begin
          frame_d = frame_q >> 1;
          if (cnt_q == '0) state_d = ST_UPDATE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_UPDATE: begin
        if (period_end) state_d = ST_IDLE;
      end
      ST_RESET_PULSE: begin
        if (period_end) begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan pins follow the state one cycle late; ready drops on the accept edge itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      sclk_q  <= 1'b0;
      sen_q   <= 1'b0;
      sin_q   <= 1'b0;
      supd_q  <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_q == ST_IDLE) && !accept;
      sclk_q  <= ((state_q == ST_SHIFT) || (state_q == ST_RESET_PULSE)) && phase;
      sen_q   <= (state_q == ST_SHIFT);
      sin_q   <= (state_q == ST_SHIFT) && frame_q[0];
      supd_q  <= (state_q == ST_UPDATE);
      srst_q  <= (state_q == ST_RESET_PULSE);
    end
  end

  assign write_ready = ready_q;
  assign scan_clk    = sclk_q;
  assign scan_en     = sen_q;
  assign scan_in     = sin_q;
  assign scan_update = supd_q;
  assign scan_reset  = srst_q;

endmodule

// File: doc/scanchain_writer.md
# scanchain_writer

- Consumes scan writes accepted by the scan-chain UART client.
- Converts each `{addr, payload}` write into a bit-serial shift onto the SCuM-V scan-chain pins, followed by an update strobe.
- Alternatively, a write with the reset flag set issues a chip scan-reset pulse instead of a shift.
- Sits between the UART client's `write_*` port and the FPGA pins driving the chip scan chain.

## Interface

Parameters:
- `ADDR_BITS`, 12, width of scan address field
- `PAYLOAD_BITS`, 160, width of scan payload field
- `HALF_PERIOD`, 4, `clk` cycles per scan_clk half-period (must be ≥1)
- `RESET_PERIODS`, 4, scan_clk periods that `scan_reset` is held on a reset write

Ports:
- `clk`  input  1  system clock; the only clock
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `write_ready`  output  1  block idle, can accept a write
- `write_valid`  input  1  write request, single-cycle or held
- `write_addr`  input  ADDR_BITS  scan address
- `write_payload`  input  PAYLOAD_BITS  scan payload
- `write_reset`  input  1  1 = issue scan reset instead of a shift
- `scan_clk`  output  1  scan clock to chip
- `scan_en`  output  1  scan shift enable
- `scan_in`  output  1  serial scan data
- `scan_update`  output  1  latch strobe after shift
- `scan_reset`  output  1  chip scan-chain reset, active-high

## Operation

- FRAME_BITS = ADDR_BITS + PAYLOAD_BITS. The frame is `{payload, addr}`, shifted LSB first: `addr[0]` goes out first and `payload[PAYLOAD_BITS-1]` goes out last.
- Handshake: a write is accepted on a rising edge where `write_valid && write_ready`. Addr, payload and reset are latched into a frame register that is independent of the inputs afterwards.
- States:
  - IDLE: `write_ready`=1, all scan outputs 0.
    - Accept with `write_reset`=0 → SHIFT.
    - Accept with `write_reset`=1 → RESET_PULSE.
  - SHIFT: `scan_en`=1. Each bit occupies 2·HALF_PERIOD cycles.
    - First half: `scan_clk`=0 with `scan_in` set to the current bit.
    - Second half: `scan_clk`=1 and `scan_in` stable. The chip samples on the rising edge.
    - After bit FRAME_BITS-1 completes → UPDATE.
  - UPDATE: `scan_en`=0, `scan_clk`=0, `scan_in`=0, `scan_update`=1 for 2·HALF_PERIOD cycles → IDLE.
  - RESET_PULSE: `scan_reset`=1 for 2·HALF_PERIOD·RESET_PERIODS cycles, `scan_clk` keeps toggling, `scan_en`=0 → IDLE. No shift and no update.
- Widths:
  - Bit counter is `$clog2(FRAME_BITS+1)` bits.
  - Phase counter is `$clog2(HALF_PERIOD)` bits, minimum 1.
  - Counters clear on every state entry.
- `write_valid` asserted while busy is ignored, not queued. Upstream holds or retries.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous).
  - The frame in progress is abandoned; there is no partial update strobe.
  - After release the block returns to IDLE.

## Timing

- Reset values: `write_ready`=0, and `scan_clk`, `scan_en`, `scan_in`, `scan_update`, `scan_reset` all 0.
- `write_ready` rises on the first `clk` edge after `reset` deasserts.
- All outputs are registered; there are no combinational paths from input to output.
- Accept at edge T:
  - `write_ready`=0 from T.
  - At T+1: `scan_en`=1, `scan_in`=`addr[0]`, `scan_clk`=0.
- Rising edge of `scan_clk` for bit i occurs at T+1+(2i+1)·HALF_PERIOD.
- `scan_update` is high from T+1+2·HALF_PERIOD·FRAME_BITS for 2·HALF_PERIOD cycles.
- `write_ready` returns to 1 at T+1+2·HALF_PERIOD·(FRAME_BITS+1).
- Reset write: `write_ready` returns to 1 at T+1+2·HALF_PERIOD·RESET_PERIODS.
- A write presented in the same cycle `write_ready` returns is accepted. Back-to-back frames have no idle gap beyond that one cycle.

## Structure

- Shared package `scanchain_pkg` holds:
  - ADDR_BITS/PAYLOAD_BITS defaults, which are shared with the UART client;
  - the state enum (IDLE, SHIFT, UPDATE, RESET_PULSE);
  - the RESET_PERIODS default.
- One sub-module, `scanchain_phase_timer`. It counts HALF_PERIOD cycles and emits `half_tick` and a toggling phase bit. It is cleared by the FSM on state entry.
- The FSM, frame shift register and bit counter live in the top module.

## Test plan

Bench parameters: ADDR_BITS=4, PAYLOAD_BITS=8, HALF_PERIOD=2, RESET_PERIODS=4.

1. **Basic shift.** Write `addr`=4'hA, `payload`=8'h5C, `write_reset`=0.
   - Required: 12 `scan_clk` rising edges with `scan_in` sampled as 0,1,0,1,0,0,1,1,1,0,1,0.
   - Then `scan_update` high for 4 cycles; `write_ready` back after 53 cycles.
2. **Reset write.** Write `write_reset`=1 with any addr/payload.
   - Required: `scan_reset` high for 16 cycles; `scan_en` and `scan_update` never asserted; `write_ready` back after 17 cycles.
3. **Ignored write while busy.** Hold `write_valid`=1 with a different payload mid-SHIFT.
   - Required: shifted bits equal the first frame, and the second write is accepted exactly on the cycle `write_ready` returns.
4. **Reset mid-shift.** Assert `reset`=0 during bit 6.
   - Required: all outputs 0 asynchronously, and no `scan_update`.
   - After release, `write_ready`=1 one edge later, and a new frame shifts correctly.
5. **Back-to-back frames.** Send payload 8'hFF then 8'h00 with no gap.
   - Required: one `write_ready` cycle between frames, and exactly one update per frame.
6. **Upstream integration.** Drive from the UART client with a one-cycle `write_valid` pulse.
   - Required: the frame is accepted and the shifted bits match the packet fields.
